// File: rtl/tdm_demux16_if.sv
// Bus bundle for the 1:16 TDM demultiplexer: serial beat inputs and the
// rebuilt parallel word with its status outputs.
interface tdm_demux16_if;
  logic        din;
  logic        din_valid;
  logic        frame_start;
  logic [15:0] f;
  logic        f_valid;
  logic [3:0]  s;
  logic        busy;
  logic        frame_err;

  // master drives the serial stream, slave is the demultiplexer
  modport master (
    output din, din_valid, frame_start,
    input  f, f_valid, s, busy, frame_err
  );

  modport slave (
    input  din, din_valid, frame_start,
    output f, f_valid, s, busy, frame_err
  );
endinterface

// File: rtl/tdm_demux16.sv
// Receive end of the 16:1 serial mux path: rebuilds the 16-bit word from
// slots 0..15 and flags completed frames and premature restarts.
//
// state | meaning
// IDLE  | waiting for a valid beat qualified by frame_start
// RUN   | frame in progress, s is the next slot expected
module tdm_demux16 (
  input  logic          clk,
  input  logic          rst,
  tdm_demux16_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [15:0] stage_q, stage_d;
  logic [15:0] f_q, f_d;
  logic        f_valid_q, f_valid_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= 4'h0;
      stage_q   <= 16'h0000;
      f_q       <= 16'h0000;
      f_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      stage_q   <= stage_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    stage_d   = stage_q;
    f_d       = f_q;
    f_valid_d = 1'b0;
    err_d     = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        IDLE: begin
          // stray beats without frame_start are dropped here
          if (bus.frame_start) begin
            stage_d = {15'h0000, bus.din};
            slot_d  = 4'h1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.frame_start) begin
            err_d   = 1'b1;
            stage_d = {15'h0000, bus.din};
            slot_d  = 4'h1;
          end else if (slot_q == 4'hF) begin
            // slot 15 bypasses staging so f is valid on this same edge
            f_d       = {bus.din, stage_q[14:0]};
            f_valid_d = 1'b1;
            stage_d   = 16'h0000;
            slot_d    = 4'h0;
            state_d   = IDLE;
          end else begin
            stage_d[slot_q] = bus.din;
            slot_d          = slot_q + 4'h1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.f         = f_q;
  assign bus.f_valid   = f_valid_q;
  assign bus.s         = slot_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.frame_err = err_q;

endmodule
